// File: rtl/alu_cmd_issuer.sv
// Command front end for a registered ALU: issues one op, captures its result and returns it.
// Latency accept->rsp_valid = 2 cycles; a stalled response (rsp_ready low) blocks new commands.
module alu_cmd_issuer #(
  parameter int W     = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [W-1:0]     cmd_a,
  input  logic [W-1:0]     cmd_b,
  input  logic [1:0]       cmd_op,
  output logic [W-1:0]     alu_a,
  output logic [W-1:0]     alu_b,
  output logic [1:0]       alu_op,
  output logic             alu_en,
  input  logic [W-1:0]     alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_data,
  output logic [1:0]       rsp_op,
  output logic             busy,
  output logic [CNT_W-1:0] op_count,
  output logic             err
);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_CAPTURE, S_RESP} state_t;

  state_t           r_state;
  logic [W-1:0]     r_alu_a;
  logic [W-1:0]     r_alu_b;
  logic [1:0]       r_alu_op;
  logic             r_alu_en;
  logic [W-1:0]     r_exp;
  logic             r_rsp_valid;
  logic [W-1:0]     r_rsp_data;
  logic [1:0]       r_rsp_op;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;
  logic             r_err;

  logic [W-1:0]     w_prod_lo;
  logic [W-1:0]     w_exp;

  // W-bit multiply keeps only the low W bits of the full product
  assign w_prod_lo = cmd_a * cmd_b;

  always_comb begin
    w_exp = '0;
    case (cmd_op)
      2'b00:   w_exp = cmd_a + cmd_b;
      2'b01:   w_exp = cmd_a & cmd_b;
      2'b10:   w_exp = w_prod_lo;
      default: w_exp = cmd_a | cmd_b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_alu_a     <= '0;
      r_alu_b     <= '0;
      r_alu_op    <= 2'b00;
      r_alu_en    <= 1'b0;
      r_exp       <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_data  <= '0;
      r_rsp_op    <= 2'b00;
      r_busy      <= 1'b0;
      r_count     <= '0;
      r_err       <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (cmd_valid) begin
            r_alu_a  <= cmd_a;
            r_alu_b  <= cmd_b;
            r_alu_op <= cmd_op;
            r_exp    <= w_exp;
            r_alu_en <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          r_alu_en <= 1'b0;
          r_state  <= S_CAPTURE;
        end
        S_CAPTURE: begin
          r_rsp_data  <= alu_result;
          r_rsp_op    <= r_alu_op;
          r_rsp_valid <= 1'b1;
          if (alu_result != r_exp) r_err <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_count     <= r_count + 1'b1;
            r_busy      <= 1'b0;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign cmd_ready = (r_state == S_IDLE);
  assign alu_a     = r_alu_a;
  assign alu_b     = r_alu_b;
  assign alu_op    = r_alu_op;
  assign alu_en    = r_alu_en;
  assign rsp_valid = r_rsp_valid;
  assign rsp_data  = r_rsp_data;
  assign rsp_op    = r_rsp_op;
  assign busy      = r_busy;
  assign op_count  = r_count;
  assign err       = r_err;

endmodule

// File: doc/alu_cmd_issuer.md
# alu_cmd_issuer

Command-side front end for the team's registered 4-bit ALU. It accepts operation commands on a valid/ready stream and drives the ALU's operand, opcode and enable inputs for exactly one cycle. It then captures the ALU's registered result and returns it on a valid/ready response stream. It also checks each result against an internal reference computation and raises a sticky error flag on any mismatch.

## Interface
Parameters:
- W, 4, operand/result width; must equal the ALU datapath width
- CNT_W, 8, width of the completed-operation counter

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- cmd_op  in  2  00 add, 01 and, 10 mul, 11 or
- alu_a  out  W  to ALU A
- alu_b  out  W  to ALU B
- alu_op  out  2  to ALU op
- alu_en  out  1  to ALU en
- alu_result  in  W  from ALU result (registered inside ALU)
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer accepts response
- rsp_data  out  W  ALU result
- rsp_op  out  2  opcode of this response
- busy  out  1  state != IDLE
- op_count  out  CNT_W  completed responses, wraps modulo 2^CNT_W
- err  out  1  sticky result-mismatch flag

## Operation
- FSM states: IDLE, ISSUE, CAPTURE, RESP.
- IDLE: cmd_ready=1. If cmd_valid is high at an edge, latch cmd_a/b/op into alu_a/b/op and into the expected-result register, then go to ISSUE.
- ISSUE: alu_en=1 for this single cycle; the ALU registers its result at the closing edge; go to CAPTURE.
- CAPTURE: alu_en=0. At the closing edge: rsp_data<=alu_result, rsp_op<=latched op, rsp_valid<=1, and err<=err|(alu_result!=expected). Go to RESP.
- RESP: hold rsp_data/rsp_op/rsp_valid stable until rsp_ready. On an edge with rsp_valid&rsp_ready: rsp_valid<=0, op_count<=op_count+1, go to IDLE.
- cmd_ready is combinational: (state==IDLE). Commands are never accepted in any other state.
- alu_a/b/op hold their last values outside ISSUE. alu_en is high only in ISSUE.
- Expected result:
  - add: (a+b) mod 2^W
  - mul: (a*b) mod 2^W, i.e. low W bits of the 2W-bit product
  - and: a&b
  - or: a|b
- err stays set until rst. It does not block operation.
- op_count wraps from 2^CNT_W-1 to 0 with no flag.
- rst has priority over every handshake at the same edge.
- Reset values: state=IDLE, alu_a=0, alu_b=0, alu_op=00, alu_en=0, rsp_valid=0, rsp_data=0, rsp_op=00, op_count=0, err=0, busy=0.
- Reset mid-operation (any state) abandons the command: no response is produced and no count is taken. rst must also drive the ALU's rst.

## Timing
- Accept edge E0. alu_en is high during E0–E1. The ALU result is valid after E1. rsp_valid rises after E2.
- Latency: command accept to rsp_valid = 2 cycles.
- Minimum spacing between accepts is 4 cycles (IDLE, ISSUE, CAPTURE, RESP with rsp_ready already high).
- Holding rsp_ready low stretches RESP indefinitely. The outputs stay frozen during the stall.
- busy is registered and high from the cycle after E0 through the response handshake edge.

## Test plan
- Add wrap: cmd a=9, b=8, op=00 -> rsp_data=0x1, rsp_op=00, rsp_valid 2 cycles after accept, err=0, op_count=1.
- Mul truncation: a=7, b=5, op=10 -> rsp_data=0x3 (35 mod 16). Then a=0xC, b=0xA with op=01 -> 0x8, and op=11 -> 0xE. err stays 0.
- Backpressure: rsp_ready low for 5 cycles after rsp_valid -> rsp_data/rsp_op stable, cmd_ready=0 throughout, a second cmd_valid is ignored until the handshake, op_count increments once.
- Reset mid-op: assert rst in CAPTURE -> next cycle all outputs at reset values, no rsp_valid, op_count=0, cmd_ready=1 after rst deasserts.
- Mismatch: force alu_result to 0x0 for a=3, b=4 add -> rsp_data=0x0, err=1. err stays 1 through later correct ops until rst.
- Counter wrap (CNT_W=2): 4 back-to-back ops with rsp_ready tied high -> op_count 1,2,3,0. Accepts are spaced exactly 4 cycles apart.
